// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic divider controller.
// Loads one of four raw {fbdsel,idsel,odsel} select words into the PLL,
// runs the relock sequence (wait for unlock, wait for lock, settle),
// parks on the initial mode between retries, and reports done/err.
// lock is asynchronous to clk and is only used after a 2-flop synchronizer.
module pll_dyn_ctrl #(
  parameter int          INIT_MODE  = 0,
  parameter logic [17:0] MODE0_SEL  = 18'h3FFBE,
  parameter logic [17:0] MODE1_SEL  = 18'h3EFBC,
  parameter logic [17:0] MODE2_SEL  = 18'h3DFBA,
  parameter logic [17:0] MODE3_SEL  = 18'h3CFB8,
  parameter int          UNLOCK_TO  = 64,
  parameter int          LOCK_TO    = 100000,
  parameter int          SETTLE_CYC = 1024,
  parameter int          RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       lock,
  output logic [5:0] fbdsel,
  output logic [5:0] idsel,
  output logic [5:0] odsel,
  output logic [1:0] mode_cur,
  output logic       busy,
  output logic       stable,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_UNLOCK,
    S_WAIT_LOCK,
    S_PARK,
    S_SETTLE,
    S_ERR
  } state_t;

  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  // Each timed state leaves in the cycle its timer holds LIMIT-1, i.e. after
  // exactly LIMIT cycles spent in that state.
  localparam logic [19:0] UNLOCK_LAST = (UNLOCK_TO  > 0) ? 20'(UNLOCK_TO  - 1) : 20'd0;
  localparam logic [19:0] LOCK_LAST   = (LOCK_TO    > 0) ? 20'(LOCK_TO    - 1) : 20'd0;
  localparam logic [19:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 20'(SETTLE_CYC - 1) : 20'd0;
  localparam logic [19:0] PARK_LAST   = 20'd15;

  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);
  localparam logic [1:0]    INIT_M    = 2'(INIT_MODE);

  // Select word per mode, indexed by mode number.
  localparam logic [17:0] MODE_SEL_TBL [4] = '{MODE0_SEL, MODE1_SEL, MODE2_SEL, MODE3_SEL};

  state_t      state_reg;
  logic [19:0] timer_reg;
  logic [19:0] timer_inc;
  logic [RW-1:0] retry_reg;
  logic [1:0]  target_reg;
  logic [1:0]  mode_cur_reg;
  logic [17:0] sel_reg;
  logic        lock_meta_reg;
  logic        lock_s_reg;
  logic        busy_reg;
  logic        stable_reg;
  logic        done_reg;
  logic        err_reg;
  logic        req_ready_reg;

  // Saturating increment: the timer holds at all-ones rather than wrapping.
  assign timer_inc = (&timer_reg) ? timer_reg : timer_reg + 20'd1;

  assign {fbdsel, idsel, odsel} = sel_reg;
  assign mode_cur  = mode_cur_reg;
  assign busy      = busy_reg;
  assign stable    = stable_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign req_ready = req_ready_reg;

  // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= lock;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  // Relock sequencer; all status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_WAIT_LOCK;
      timer_reg     <= 20'd0;
      retry_reg     <= '0;
      target_reg    <= INIT_M;
      mode_cur_reg  <= INIT_M;
      sel_reg       <= MODE_SEL_TBL[INIT_M];
      busy_reg      <= 1'b1;
      stable_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      req_ready_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            if (req_mode == mode_cur_reg) begin
              // Already running this mode: acknowledge without touching the PLL.
              done_reg <= 1'b1;
            end else begin
              target_reg    <= req_mode;
              retry_reg     <= '0;
              state_reg     <= S_LOAD;
              busy_reg      <= 1'b1;
              stable_reg    <= 1'b0;
              req_ready_reg <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          sel_reg      <= MODE_SEL_TBL[target_reg];
          mode_cur_reg <= target_reg;
          timer_reg    <= 20'd0;
          state_reg    <= S_WAIT_UNLOCK;
        end

        S_WAIT_UNLOCK: begin
          // Small ratio changes may never drop lock, so give up after a bound.
          if (!lock_s_reg || (timer_reg >= UNLOCK_LAST)) begin
            state_reg <= S_WAIT_LOCK;
            timer_reg <= 20'd0;
          end else begin
            timer_reg <= timer_inc;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s_reg) begin
            state_reg <= S_SETTLE;
            timer_reg <= 20'd0;
          end else if (timer_reg >= LOCK_LAST) begin
            timer_reg <= 20'd0;
            if (retry_reg < RETRY_MAX) begin
              retry_reg <= retry_reg + 1'b1;
              sel_reg   <= MODE_SEL_TBL[INIT_M];
              state_reg <= S_PARK;
            end else begin
              state_reg     <= S_ERR;
              err_reg       <= 1'b1;
              busy_reg      <= 1'b0;
              req_ready_reg <= 1'b1;
            end
          end else begin
            timer_reg <= timer_inc;
          end
        end

        S_PARK: begin
          // Sit on the known-good mode before retrying the target.
          if (timer_reg >= PARK_LAST) begin
            sel_reg   <= MODE_SEL_TBL[target_reg];
            timer_reg <= 20'd0;
            state_reg <= S_LOAD;
          end else begin
            timer_reg <= timer_inc;
          end
        end

        S_SETTLE: begin
          if (!lock_s_reg) begin
            state_reg <= S_WAIT_LOCK;
            timer_reg <= 20'd0;
          end else if (timer_reg >= SETTLE_LAST) begin
            state_reg     <= S_IDLE;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            stable_reg    <= 1'b1;
            req_ready_reg <= 1'b1;
          end else begin
            timer_reg <= timer_inc;
          end
        end

        S_ERR: begin
          if (req_valid) begin
            target_reg    <= req_mode;
            retry_reg     <= '0;
            state_reg     <= S_LOAD;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            req_ready_reg <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: fall into the error state so software can recover.
          state_reg     <= S_ERR;
          err_reg       <= 1'b1;
          busy_reg      <= 1'b0;
          stable_reg    <= 1'b0;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Testbench for pll_dyn_ctrl: table of mode-change requests plus hand-written
// sequences for power-up, retry/error, settle glitch, busy requests and reset.
module tb_pll_dyn_ctrl;

  localparam logic [17:0] SEL0 = 18'h3FFBE;
  localparam logic [17:0] SEL1 = 18'h3EFBC;
  localparam logic [17:0] SEL2 = 18'h3DFBA;
  localparam logic [17:0] SEL3 = 18'h3CFB8;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       lock;
  logic [5:0] fbdsel;
  logic [5:0] idsel;
  logic [5:0] odsel;
  logic [1:0] mode_cur;
  logic       busy;
  logic       stable;
  logic       done;
  logic       err;
  logic [17:0] sel;

  assign sel = {fbdsel, idsel, odsel};

  pll_dyn_ctrl #(
    .INIT_MODE (0),
    .MODE0_SEL (SEL0),
    .MODE1_SEL (SEL1),
    .MODE2_SEL (SEL2),
    .MODE3_SEL (SEL3),
    .UNLOCK_TO (64),
    .LOCK_TO   (400),
    .SETTLE_CYC(1024),
    .RETRIES   (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_mode (req_mode),
    .req_ready(req_ready),
    .lock     (lock),
    .fbdsel   (fbdsel),
    .idsel    (idsel),
    .odsel    (odsel),
    .mode_cur (mode_cur),
    .busy     (busy),
    .stable   (stable),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Running observations, updated only by the stimulus process via step().
  int          done_seen     = 0;
  int          park_entries  = 0;
  int          park_cycles   = 0;
  logic [17:0] prev_sel      = 18'h0;

  typedef struct {
    logic [1:0]  mode;
    bit          drop;
    bit          same;
    logic [17:0] exp_sel;
    int          min_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic step();
    @(negedge clk);
    if (done) done_seen++;
    if (sel == SEL0 && prev_sel != SEL0) park_entries++;
    if (sel == SEL0) park_cycles++;
    prev_sel = sel;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < bound && !ok) begin
      step();
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;
    int d0;
    int pe0;
    int pc0;

    vecs[0] = '{mode: 2'd2, drop: 1'b1, same: 1'b0, exp_sel: SEL2, min_lat: 1024 + 200};
    vecs[1] = '{mode: 2'd1, drop: 1'b0, same: 1'b0, exp_sel: SEL1, min_lat: 1024 + 64};
    vecs[2] = '{mode: 2'd1, drop: 1'b0, same: 1'b1, exp_sel: SEL1, min_lat: 0};
    vecs[3] = '{mode: 2'd3, drop: 1'b1, same: 1'b0, exp_sel: SEL3, min_lat: 1024 + 200};
    vecs[4] = '{mode: 2'd0, drop: 1'b1, same: 1'b0, exp_sel: SEL0, min_lat: 1024 + 200};
    vecs[5] = '{mode: 2'd0, drop: 1'b0, same: 1'b1, exp_sel: SEL0, min_lat: 0};

    // Reset state
    reset = 1'b1; lock = 1'b0; req_valid = 1'b0; req_mode = 2'd0;
    repeat (3) step();
    check("rst_sel",      sel,       SEL0);
    check("rst_mode_cur", mode_cur,  2'd0);
    check("rst_busy",     busy,      1'b1);
    check("rst_stable",   stable,    1'b0);
    check("rst_done",     done,      1'b0);
    check("rst_err",      err,       1'b0);
    check("rst_ready",    req_ready, 1'b0);

    // Power-up: lock rises 50 cycles after reset, then 1024-cycle settle
    reset = 1'b0;
    d0 = done_seen;
    repeat (50) step();
    check("pwr_busy_before_lock", busy, 1'b1);
    lock = 1'b1;
    wait_done(2000, cyc, ok);
    check("pwr_done_seen", ok, 1'b1);
    check_range("pwr_done_latency", 50 + cyc, 1070, 1085);
    check("pwr_stable", stable, 1'b1);
    check("pwr_busy",   busy,   1'b0);
    check("pwr_sel",    sel,    SEL0);
    step();
    check("pwr_done_pulse_width", done, 1'b0);
    check("pwr_done_count", done_seen - d0, 1);

    // Table of mode-change requests from IDLE
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_mode  = vecs[i].mode;
      check($sformatf("v%0d_ready", i), req_ready, 1'b1);
      d0 = done_seen;
      step();
      req_valid = 1'b0;
      if (vecs[i].same) begin
        check($sformatf("v%0d_same_done", i),   done,   1'b1);
        check($sformatf("v%0d_same_busy", i),   busy,   1'b0);
        check($sformatf("v%0d_same_stable", i), stable, 1'b1);
        check($sformatf("v%0d_same_sel", i),    sel,    vecs[i].exp_sel);
        step();
        check($sformatf("v%0d_same_done_off", i), done, 1'b0);
      end else begin
        check($sformatf("v%0d_busy", i),   busy,   1'b1);
        check($sformatf("v%0d_stable", i), stable, 1'b0);
        step();
        check($sformatf("v%0d_sel", i),      sel,      vecs[i].exp_sel);
        check($sformatf("v%0d_mode_cur", i), mode_cur, vecs[i].mode);
        if (vecs[i].drop) begin
          repeat (5) step();
          lock = 1'b0;
          repeat (200) step();
          lock = 1'b1;
        end
        wait_done(3000, cyc, ok);
        check($sformatf("v%0d_done_seen", i), ok, 1'b1);
        check_range($sformatf("v%0d_latency", i), (vecs[i].drop ? 205 : 0) + cyc,
                    vecs[i].min_lat, vecs[i].min_lat + 40);
        repeat (3) step();
        check($sformatf("v%0d_done_count", i), done_seen - d0, 1);
        check($sformatf("v%0d_idle_busy", i),  busy,      1'b0);
        check($sformatf("v%0d_idle_stab", i),  stable,    1'b1);
        check($sformatf("v%0d_idle_rdy", i),   req_ready, 1'b1);
      end
    end

    // Lock glitch at settle count ~500 restarts the full settle
    req_valid = 1'b1; req_mode = 2'd2;
    d0 = done_seen;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    lock = 1'b0;
    repeat (200) step();
    lock = 1'b1;
    repeat (503) step();
    lock = 1'b0;
    repeat (3) step();
    lock = 1'b1;
    check("glitch_no_early_done", done_seen - d0, 0);
    wait_done(2000, cyc, ok);
    check("glitch_done_seen", ok, 1'b1);
    check_range("glitch_resettle_latency", cyc, 1020, 1035);
    repeat (3) step();
    check("glitch_done_count", done_seen - d0, 1);
    check("glitch_sel", sel, SEL2);

    // Lock stuck low: 4 timeouts, 3 parks of 16 cycles on SEL0, then err
    lock = 1'b0;
    repeat (3) step();
    pe0 = park_entries;
    pc0 = park_cycles;
    d0  = done_seen;
    req_valid = 1'b1; req_mode = 2'd3;
    cyc = 0;
    step();
    cyc++;
    req_valid = 1'b0;
    while (!err && cyc < 3000) begin
      step();
      cyc++;
    end
    check("err_reached", err, 1'b1);
    check_range("err_latency", cyc, 1640, 1680);
    check("err_park_entries", park_entries - pe0, 3);
    check("err_park_cycles",  park_cycles - pc0, 48);
    check("err_busy",     busy,      1'b0);
    check("err_stable",   stable,    1'b0);
    check("err_ready",    req_ready, 1'b1);
    check("err_sel_hold", sel,       SEL3);
    check("err_mode_cur", mode_cur,  2'd3);
    check("err_no_done",  done_seen - d0, 0);

    // New request clears err
    lock = 1'b1;
    req_valid = 1'b1; req_mode = 2'd1;
    step();
    req_valid = 1'b0;
    check("errclr_err",  err,  1'b0);
    check("errclr_busy", busy, 1'b1);
    wait_done(3000, cyc, ok);
    check("errclr_done_seen", ok, 1'b1);
    check("errclr_sel", sel, SEL1);

    // Requests while busy are ignored; reset mid-settle aborts
    step();
    req_valid = 1'b1; req_mode = 2'd2;
    step();
    req_valid = 1'b0;
    lock = 1'b0;
    repeat (20) step();
    check("busy_ready_low", req_ready, 1'b0);
    req_valid = 1'b1; req_mode = 2'd3;
    repeat (3) step();
    req_valid = 1'b0;
    check("busy_req_ignored_mode", mode_cur, 2'd2);
    check("busy_req_ignored_sel",  sel,      SEL2);
    check("busy_still_busy",       busy,     1'b1);
    d0 = done_seen;
    lock = 1'b1;
    repeat (300) step();
    check("midsettle_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    check("abort_sel",      sel,      SEL0);
    check("abort_busy",     busy,     1'b1);
    check("abort_mode_cur", mode_cur, 2'd0);
    check("abort_stable",   stable,   1'b0);
    check("abort_err",      err,      1'b0);
    lock = 1'b0;
    step();
    reset = 1'b0;
    repeat (200) step();
    check("abort_no_done",   done_seen - d0, 0);
    check("abort_busy_hold", busy, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
